// File: rtl/rob_retire_ctrl.sv
// In-order reorder buffer: 2-wide allocate, 2 completion ports, 4-wide in-order retire, 1-cycle flush.
// Optional macro ROB_STALL_CNT_EN adds the RetireStallCnt retire-stall counter output.
module rob_retire_ctrl #(
    parameter int ROBDEEP  = 16,
    parameter int ROBPTRW  = 4,
    parameter int PHYRPTRW = 7
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                AllocValid1,
    input  logic                AllocValid2,
    input  logic                AllocWen1,
    input  logic                AllocWen2,
    input  logic [4:0]          AllocAR1,
    input  logic [4:0]          AllocAR2,
    input  logic [PHYRPTRW-1:0] AllocPR1,
    input  logic [PHYRPTRW-1:0] AllocPR2,
    input  logic [PHYRPTRW-1:0] AllocOldPR1,
    input  logic [PHYRPTRW-1:0] AllocOldPR2,
    output logic                AllocReady,
    output logic [ROBPTRW-1:0]  AllocIdx1,
    output logic [ROBPTRW-1:0]  AllocIdx2,
    input  logic                CmpValid1,
    input  logic                CmpValid2,
    input  logic [ROBPTRW-1:0]  CmpIdx1,
    input  logic [ROBPTRW-1:0]  CmpIdx2,
    input  logic                CmpExc1,
    input  logic                CmpExc2,
    output logic                RetireReg1Able,
    output logic                RetireReg2Able,
    output logic                RetireReg3Able,
    output logic                RetireReg4Able,
    output logic [4:0]          RetireAR1Addr,
    output logic [4:0]          RetireAR2Addr,
    output logic [4:0]          RetireAR3Addr,
    output logic [4:0]          RetireAR4Addr,
    output logic [PHYRPTRW-1:0] RetirePR1Addr,
    output logic [PHYRPTRW-1:0] RetirePR2Addr,
    output logic [PHYRPTRW-1:0] RetirePR3Addr,
    output logic [PHYRPTRW-1:0] RetirePR4Addr,
    output logic                FreeValid1,
    output logic                FreeValid2,
    output logic                FreeValid3,
    output logic                FreeValid4,
    output logic [PHYRPTRW-1:0] FreePR1,
    output logic [PHYRPTRW-1:0] FreePR2,
    output logic [PHYRPTRW-1:0] FreePR3,
    output logic [PHYRPTRW-1:0] FreePR4,
    output logic                ReMapping,
    output logic                FlushReq
`ifdef ROB_STALL_CNT_EN
    ,
    output logic [31:0]         RetireStallCnt
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ROBPTRW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROBPTRW:0]      count_q, count_d;
    logic [ROBDEEP-1:0]    valid_q, valid_d, done_q, done_d, exc_q, exc_d, wen_q, wen_d;
    logic [4:0]            ar_q    [ROBDEEP];
    logic [4:0]            ar_d    [ROBDEEP];
    logic [PHYRPTRW-1:0]   pr_q    [ROBDEEP];
    logic [PHYRPTRW-1:0]   pr_d    [ROBDEEP];
    logic [PHYRPTRW-1:0]   oldpr_q [ROBDEEP];
    logic [PHYRPTRW-1:0]   oldpr_d [ROBDEEP];

    logic                  alloc_fire1, alloc_fire2;
    logic [ROBPTRW:0]      alloc_n;
    logic [ROBPTRW-1:0]    tail_p1;
    logic [ROBPTRW-1:0]    ret_idx [4];
    logic [3:0]            ret_ok;
    logic [2:0]            ret_cnt;
    logic                  chain;
    logic                  ret_able  [4];
    logic [4:0]            ret_ar    [4];
    logic [PHYRPTRW-1:0]   ret_pr    [4];
    logic [PHYRPTRW-1:0]   ret_oldpr [4];

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (Rest) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // FSM: next state; an excepting head triggers the flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (valid_q[head_q] && done_q[head_q] && exc_q[head_q]) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ReMapping  = (state_q == ST_FLUSH);
        FlushReq   = (state_q == ST_FLUSH);
        AllocReady = (state_q == ST_RUN) && (count_q <= (ROBPTRW+1)'(ROBDEEP-2));
    end

    assign tail_p1   = tail_q + 1'b1;
    assign AllocIdx1 = tail_q;
    assign AllocIdx2 = tail_p1;

    // Retire window: a slot retires only if every older slot also retires
    always_comb begin
        ret_ok  = '0;
        ret_cnt = '0;
        chain   = (state_q == ST_RUN);
        for (int k = 0; k < 4; k++) begin
            ret_idx[k] = head_q + ROBPTRW'(k);
            chain = chain && (count_q > (ROBPTRW+1)'(k)) && valid_q[ret_idx[k]]
                    && done_q[ret_idx[k]] && !exc_q[ret_idx[k]];
            ret_ok[k] = chain;
            if (chain) ret_cnt = 3'(k + 1);
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ret_able[k]  = 1'b0;
            ret_ar[k]    = '0;
            ret_pr[k]    = '0;
            ret_oldpr[k] = '0;
            if (ret_ok[k]) begin
                ret_able[k]  = wen_q[ret_idx[k]];
                ret_ar[k]    = ar_q[ret_idx[k]];
                ret_pr[k]    = pr_q[ret_idx[k]];
                ret_oldpr[k] = oldpr_q[ret_idx[k]];
            end
        end
    end

    assign RetireReg1Able = ret_able[0];
    assign RetireReg2Able = ret_able[1];
    assign RetireReg3Able = ret_able[2];
    assign RetireReg4Able = ret_able[3];
    assign RetireAR1Addr  = ret_ar[0];
    assign RetireAR2Addr  = ret_ar[1];
    assign RetireAR3Addr  = ret_ar[2];
    assign RetireAR4Addr  = ret_ar[3];
    assign RetirePR1Addr  = ret_pr[0];
    assign RetirePR2Addr  = ret_pr[1];
    assign RetirePR3Addr  = ret_pr[2];
    assign RetirePR4Addr  = ret_pr[3];
    assign FreeValid1     = ret_able[0];
    assign FreeValid2     = ret_able[1];
    assign FreeValid3     = ret_able[2];
    assign FreeValid4     = ret_able[3];
    assign FreePR1        = ret_oldpr[0];
    assign FreePR2        = ret_oldpr[1];
    assign FreePR3        = ret_oldpr[2];
    assign FreePR4        = ret_oldpr[3];

    assign alloc_fire1 = AllocReady && AllocValid1;
    assign alloc_fire2 = alloc_fire1 && AllocValid2;
    assign alloc_n     = (ROBPTRW+1)'(alloc_fire1) + (ROBPTRW+1)'(alloc_fire2);

    // Entry, pointer and occupancy update
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        wen_d   = wen_q;
        ar_d    = ar_q;
        pr_d    = pr_q;
        oldpr_d = oldpr_q;
        head_d  = head_q + ROBPTRW'(ret_cnt);
        tail_d  = tail_q + alloc_n[ROBPTRW-1:0];
        count_d = count_q + alloc_n - (ROBPTRW+1)'(ret_cnt);
        for (int k = 0; k < 4; k++) begin
            if (ret_ok[k]) valid_d[ret_idx[k]] = 1'b0;
        end
        if (state_q == ST_RUN) begin
            if (CmpValid1 && valid_q[CmpIdx1]) begin
                done_d[CmpIdx1] = 1'b1;
                if (CmpExc1) exc_d[CmpIdx1] = 1'b1;
            end
            if (CmpValid2 && valid_q[CmpIdx2]) begin
                done_d[CmpIdx2] = 1'b1;
                if (CmpExc2) exc_d[CmpIdx2] = 1'b1;
            end
        end
        if (alloc_fire1) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            exc_d[tail_q]   = 1'b0;
            wen_d[tail_q]   = AllocWen1;
            ar_d[tail_q]    = AllocAR1;
            pr_d[tail_q]    = AllocPR1;
            oldpr_d[tail_q] = AllocOldPR1;
        end
        if (alloc_fire2) begin
            valid_d[tail_p1] = 1'b1;
            done_d[tail_p1]  = 1'b0;
            exc_d[tail_p1]   = 1'b0;
            wen_d[tail_p1]   = AllocWen2;
            ar_d[tail_p1]    = AllocAR2;
            pr_d[tail_p1]    = AllocPR2;
            oldpr_d[tail_p1] = AllocOldPR2;
        end
        if (state_q == ST_FLUSH) begin
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    // Payload fields are qualified by valid_q, so they carry no reset
    always_ff @(posedge Clk) begin
        wen_q   <= wen_d;
        ar_q    <= ar_d;
        pr_q    <= pr_d;
        oldpr_q <= oldpr_d;
    end

`ifdef ROB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && (count_q != '0) && (ret_cnt == '0) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge Clk) begin
        if (Rest) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign RetireStallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed self-checking bench for rob_retire_ctrl: fill/wrap, 4-wide retire, head blocking,
// exception flush, no-writeback retire and reset during flush.
module tb_rob_retire_ctrl;
    logic       Clk = 1'b0;
    logic       Rest;
    logic       AllocValid1, AllocValid2, AllocWen1, AllocWen2;
    logic [4:0] AllocAR1, AllocAR2;
    logic [6:0] AllocPR1, AllocPR2, AllocOldPR1, AllocOldPR2;
    logic       AllocReady;
    logic [3:0] AllocIdx1, AllocIdx2;
    logic       CmpValid1, CmpValid2, CmpExc1, CmpExc2;
    logic [3:0] CmpIdx1, CmpIdx2;
    logic       RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able;
    logic [4:0] RetireAR1Addr, RetireAR2Addr, RetireAR3Addr, RetireAR4Addr;
    logic [6:0] RetirePR1Addr, RetirePR2Addr, RetirePR3Addr, RetirePR4Addr;
    logic       FreeValid1, FreeValid2, FreeValid3, FreeValid4;
    logic [6:0] FreePR1, FreePR2, FreePR3, FreePR4;
    logic       ReMapping, FlushReq;
`ifdef ROB_STALL_CNT_EN
    logic [31:0] RetireStallCnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    rob_retire_ctrl #(.ROBDEEP(16), .ROBPTRW(4), .PHYRPTRW(7)) dut (
        .Clk(Clk), .Rest(Rest),
        .AllocValid1(AllocValid1), .AllocValid2(AllocValid2),
        .AllocWen1(AllocWen1), .AllocWen2(AllocWen2),
        .AllocAR1(AllocAR1), .AllocAR2(AllocAR2),
        .AllocPR1(AllocPR1), .AllocPR2(AllocPR2),
        .AllocOldPR1(AllocOldPR1), .AllocOldPR2(AllocOldPR2),
        .AllocReady(AllocReady), .AllocIdx1(AllocIdx1), .AllocIdx2(AllocIdx2),
        .CmpValid1(CmpValid1), .CmpValid2(CmpValid2),
        .CmpIdx1(CmpIdx1), .CmpIdx2(CmpIdx2),
        .CmpExc1(CmpExc1), .CmpExc2(CmpExc2),
        .RetireReg1Able(RetireReg1Able), .RetireReg2Able(RetireReg2Able),
        .RetireReg3Able(RetireReg3Able), .RetireReg4Able(RetireReg4Able),
        .RetireAR1Addr(RetireAR1Addr), .RetireAR2Addr(RetireAR2Addr),
        .RetireAR3Addr(RetireAR3Addr), .RetireAR4Addr(RetireAR4Addr),
        .RetirePR1Addr(RetirePR1Addr), .RetirePR2Addr(RetirePR2Addr),
        .RetirePR3Addr(RetirePR3Addr), .RetirePR4Addr(RetirePR4Addr),
        .FreeValid1(FreeValid1), .FreeValid2(FreeValid2),
        .FreeValid3(FreeValid3), .FreeValid4(FreeValid4),
        .FreePR1(FreePR1), .FreePR2(FreePR2), .FreePR3(FreePR3), .FreePR4(FreePR4),
        .ReMapping(ReMapping), .FlushReq(FlushReq)
`ifdef ROB_STALL_CNT_EN
        , .RetireStallCnt(RetireStallCnt)
`endif
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        AllocValid1 = 0; AllocValid2 = 0; AllocWen1 = 0; AllocWen2 = 0;
        AllocAR1 = 0; AllocAR2 = 0; AllocPR1 = 0; AllocPR2 = 0;
        AllocOldPR1 = 0; AllocOldPR2 = 0;
        CmpValid1 = 0; CmpValid2 = 0; CmpIdx1 = 0; CmpIdx2 = 0; CmpExc1 = 0; CmpExc2 = 0;
    endtask

    task automatic do_reset();
        clr();
        Rest = 1;
        tick();
        tick();
        Rest = 0;
    endtask

    task automatic alloc(input logic v2, input logic w1, input logic [4:0] a1, input logic [6:0] p1,
                         input logic [6:0] o1, input logic w2, input logic [4:0] a2,
                         input logic [6:0] p2, input logic [6:0] o2);
        AllocValid1 = 1; AllocValid2 = v2;
        AllocWen1 = w1; AllocAR1 = a1; AllocPR1 = p1; AllocOldPR1 = o1;
        AllocWen2 = w2; AllocAR2 = a2; AllocPR2 = p2; AllocOldPR2 = o2;
        tick();
        AllocValid1 = 0; AllocValid2 = 0;
    endtask

    task automatic cmp(input logic v1, input logic [3:0] i1, input logic e1,
                       input logic v2, input logic [3:0] i2, input logic e2);
        CmpValid1 = v1; CmpIdx1 = i1; CmpExc1 = e1;
        CmpValid2 = v2; CmpIdx2 = i2; CmpExc2 = e2;
        tick();
        CmpValid1 = 0; CmpValid2 = 0; CmpExc1 = 0; CmpExc2 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({AllocReady, AllocIdx1, AllocIdx2} !== {1'b1, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL reset_alloc ready/idx1/idx2=%b/%0d/%0d exp 1/0/1", AllocReady, AllocIdx1, AllocIdx2);
        end
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able, FreeValid1, FreeValid2,
             FreeValid3, FreeValid4, ReMapping, FlushReq, RetirePR1Addr, RetireAR1Addr, FreePR1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs able=%b%b%b%b remap=%b flush=%b pr1=%0d exp all 0",
                     RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able, ReMapping, FlushReq, RetirePR1Addr);
        end
`ifdef ROB_STALL_CNT_EN
        checks++;
        if (RetireStallCnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stallcnt got=%0d exp=0", RetireStallCnt);
        end
`endif
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({AllocReady, AllocIdx1, AllocIdx2} !== {1'b1, 4'(2*i), 4'(2*i+1)}) begin
                errors++;
                $display("FAIL fill_step%0d ready/idx1/idx2=%b/%0d/%0d exp 1/%0d/%0d",
                         i, AllocReady, AllocIdx1, AllocIdx2, 2*i, 2*i+1);
            end
            alloc(1, 1, 5'(i), 7'(2*i), 7'(100+i), 1, 5'(i+8), 7'(2*i+1), 7'(110+i));
        end
        checks++;
        if ({AllocReady, AllocIdx1, AllocIdx2} !== {1'b0, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL fill_full ready/idx1/idx2=%b/%0d/%0d exp 0/0/1", AllocReady, AllocIdx1, AllocIdx2);
        end
        alloc(1, 1, 5'd31, 7'd99, 7'd99, 1, 5'd31, 7'd99, 7'd99);
        checks++;
        if ({AllocReady, AllocIdx1, RetireReg1Able} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL fill_ignored ready/idx1/able1=%b/%0d/%b exp 0/0/0", AllocReady, AllocIdx1, RetireReg1Able);
        end
        cmp(1, 4'd0, 0, 1, 4'd1, 0);
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetirePR1Addr, RetirePR2Addr, AllocReady}
            !== {1'b1, 1'b1, 1'b0, 7'd0, 7'd1, 1'b0}) begin
            errors++;
            $display("FAIL fill_retire able=%b%b%b pr1=%0d pr2=%0d ready=%b exp 110 0 1 0",
                     RetireReg1Able, RetireReg2Able, RetireReg3Able, RetirePR1Addr, RetirePR2Addr, AllocReady);
        end
        tick();
        checks++;
        if ({AllocReady, RetireReg1Able} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fill_drain ready/able1=%b/%b exp 1/0", AllocReady, RetireReg1Able);
        end
    endtask

    task automatic test_retire4();
        do_reset();
        alloc(1, 1, 5'd1, 7'd40, 7'd1, 1, 5'd2, 7'd41, 7'd2);
        alloc(1, 1, 5'd3, 7'd42, 7'd3, 1, 5'd4, 7'd43, 7'd4);
        cmp(1, 4'd2, 0, 1, 4'd3, 0);
        CmpValid1 = 1; CmpIdx1 = 4'd0; CmpValid2 = 1; CmpIdx2 = 4'd1;
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able} !== 4'b0000) begin
            errors++;
            $display("FAIL r4_early able=%b%b%b%b exp 0000", RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able);
        end
        tick();
        clr();
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able} !== 4'b1111) begin
            errors++;
            $display("FAIL r4_able able=%b%b%b%b exp 1111", RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able);
        end
        checks++;
        if ({RetirePR1Addr, RetirePR2Addr, RetirePR3Addr, RetirePR4Addr} !== {7'd40, 7'd41, 7'd42, 7'd43}) begin
            errors++;
            $display("FAIL r4_pr pr=%0d,%0d,%0d,%0d exp 40,41,42,43", RetirePR1Addr, RetirePR2Addr, RetirePR3Addr, RetirePR4Addr);
        end
        checks++;
        if ({RetireAR1Addr, RetireAR2Addr, RetireAR3Addr, RetireAR4Addr, FreeValid1, FreeValid2, FreeValid3,
             FreeValid4, FreePR1, FreePR2, FreePR3, FreePR4}
            !== {5'd1, 5'd2, 5'd3, 5'd4, 4'b1111, 7'd1, 7'd2, 7'd3, 7'd4}) begin
            errors++;
            $display("FAIL r4_ar_free ar=%0d,%0d,%0d,%0d free=%0d,%0d,%0d,%0d exp 1..4 / 1..4",
                     RetireAR1Addr, RetireAR2Addr, RetireAR3Addr, RetireAR4Addr, FreePR1, FreePR2, FreePR3, FreePR4);
        end
        tick();
        checks++;
        if ({RetireReg1Able, AllocIdx1, AllocReady} !== {1'b0, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL r4_after able1/idx1/ready=%b/%0d/%b exp 0/4/1", RetireReg1Able, AllocIdx1, AllocReady);
        end
    endtask

    task automatic test_head_block();
        alloc(1, 1, 5'd5, 7'd50, 7'd10, 1, 5'd6, 7'd51, 7'd11);
        alloc(1, 1, 5'd7, 7'd52, 7'd12, 1, 5'd8, 7'd53, 7'd13);
        cmp(1, 4'd5, 0, 1, 4'd6, 0);
        cmp(1, 4'd7, 0, 0, 4'd0, 0);
        tick();
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able, RetirePR2Addr} !== {4'b0000, 7'd0}) begin
            errors++;
            $display("FAIL hb_blocked able=%b%b%b%b pr2=%0d exp 0000/0", RetireReg1Able, RetireReg2Able,
                     RetireReg3Able, RetireReg4Able, RetirePR2Addr);
        end
        cmp(1, 4'd4, 0, 0, 4'd0, 0);
        checks++;
        if ({RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able, RetirePR1Addr, RetirePR4Addr, FreePR4}
            !== {4'b1111, 7'd50, 7'd53, 7'd13}) begin
            errors++;
            $display("FAIL hb_release able=%b%b%b%b pr1=%0d pr4=%0d free4=%0d exp 1111/50/53/13", RetireReg1Able,
                     RetireReg2Able, RetireReg3Able, RetireReg4Able, RetirePR1Addr, RetirePR4Addr, FreePR4);
        end
        tick();
    endtask

    task automatic test_exception();
        do_reset();
        alloc(1, 1, 5'd1, 7'd60, 7'd20, 1, 5'd2, 7'd61, 7'd21);
        alloc(1, 1, 5'd3, 7'd62, 7'd22, 1, 5'd4, 7'd63, 7'd23);
        cmp(1, 4'd2, 0, 1, 4'd3, 0);
        cmp(1, 4'd0, 0, 1, 4'd1, 1);
        checks++;
        if ({RetireReg1Able, RetirePR1Addr, FreePR1, RetireReg2Able, RetireReg3Able, ReMapping}
            !== {1'b1, 7'd60, 7'd20, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL exc_slot1 able1=%b pr1=%0d free1=%0d able2=%b able3=%b remap=%b exp 1/60/20/0/0/0",
                     RetireReg1Able, RetirePR1Addr, FreePR1, RetireReg2Able, RetireReg3Able, ReMapping);
        end
        tick();
        checks++;
        if ({RetireReg1Able, ReMapping, FlushReq} !== 3'b000) begin
            errors++;
            $display("FAIL exc_head able1/remap/flush=%b/%b/%b exp 0/0/0", RetireReg1Able, ReMapping, FlushReq);
        end
        tick();
        checks++;
        if ({ReMapping, FlushReq, AllocReady, RetireReg1Able, FreeValid1} !== 5'b11000) begin
            errors++;
            $display("FAIL exc_flush remap/flush/ready/able1/free1=%b/%b/%b/%b/%b exp 1/1/0/0/0",
                     ReMapping, FlushReq, AllocReady, RetireReg1Able, FreeValid1);
        end
        tick();
        checks++;
        if ({ReMapping, FlushReq, AllocReady, AllocIdx1, RetireReg1Able} !== {3'b001, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL exc_after remap/flush/ready/idx1/able1=%b/%b/%b/%0d/%b exp 0/0/1/0/0",
                     ReMapping, FlushReq, AllocReady, AllocIdx1, RetireReg1Able);
        end
    endtask

    task automatic test_nowen();
        do_reset();
        alloc(1, 0, 5'd9, 7'd70, 7'd30, 1, 5'd10, 7'd71, 7'd31);
        cmp(1, 4'd0, 0, 1, 4'd1, 0);
        checks++;
        if ({RetireReg1Able, FreeValid1, RetirePR1Addr, FreePR1, RetireReg2Able, FreeValid2, RetirePR2Addr}
            !== {1'b0, 1'b0, 7'd70, 7'd30, 1'b1, 1'b1, 7'd71}) begin
            errors++;
            $display("FAIL nowen_retire able1=%b free1=%b pr1=%0d fpr1=%0d able2=%b free2=%b pr2=%0d exp 0/0/70/30/1/1/71",
                     RetireReg1Able, FreeValid1, RetirePR1Addr, FreePR1, RetireReg2Able, FreeValid2, RetirePR2Addr);
        end
        alloc(0, 1, 5'd11, 7'd72, 7'd32, 0, 5'd0, 7'd0, 7'd0);
        cmp(1, 4'd2, 0, 0, 4'd0, 0);
        checks++;
        if ({RetireReg1Able, RetirePR1Addr, RetireAR1Addr, RetireReg2Able, AllocIdx1} !== {1'b1, 7'd72, 5'd11, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL nowen_head able1=%b pr1=%0d ar1=%0d able2=%b idx1=%0d exp 1/72/11/0/3",
                     RetireReg1Able, RetirePR1Addr, RetireAR1Addr, RetireReg2Able, AllocIdx1);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        do_reset();
        alloc(0, 1, 5'd12, 7'd80, 7'd40, 0, 5'd0, 7'd0, 7'd0);
        cmp(1, 4'd0, 1, 0, 4'd0, 0);
        tick();
        checks++;
        if (ReMapping !== 1'b1) begin
            errors++;
            $display("FAIL fr_inflush remap=%b exp 1", ReMapping);
        end
        Rest = 1;
        tick();
        Rest = 0;
        checks++;
        if ({ReMapping, FlushReq, AllocReady, AllocIdx1, AllocIdx2, RetireReg1Able, FreeValid1}
            !== {3'b001, 4'd0, 4'd1, 2'b00}) begin
            errors++;
            $display("FAIL fr_reset remap/flush/ready/idx1/idx2/able1/free1=%b/%b/%b/%0d/%0d/%b/%b exp 0/0/1/0/1/0/0",
                     ReMapping, FlushReq, AllocReady, AllocIdx1, AllocIdx2, RetireReg1Able, FreeValid1);
        end
`ifdef ROB_STALL_CNT_EN
        checks++;
        if (RetireStallCnt !== 32'd0) begin
            errors++;
            $display("FAIL fr_stallcnt got=%0d exp=0", RetireStallCnt);
        end
`endif
        tick();
        checks++;
        if ({ReMapping, AllocReady} !== 2'b01) begin
            errors++;
            $display("FAIL fr_hold remap/ready=%b/%b exp 0/1", ReMapping, AllocReady);
        end
    endtask

    initial begin
        Rest = 1;
        clr();
        test_reset();
        test_fill();
        test_retire4();
        test_head_block();
        test_exception();
        test_nowen();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
